// File: rtl/counter_hours.sv
// Hour stage of the clock chain: BCD 00-23 counter with run/set modes,
// midnight day carry and a registered 24h/12h display copy with PM flag.
module counter_hours (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_hour,
    input  logic       up,
    input  logic       down,
    input  logic       tick_hour,
    input  logic       fmt_12h,
    output logic [3:0] hour_unit,
    output logic [3:0] hour_ten,
    output logic [3:0] disp_unit,
    output logic [3:0] disp_ten,
    output logic       pm,
    output logic       tick_day
);

    logic [3:0] hour_unit_q, hour_unit_d;
    logic [3:0] hour_ten_q, hour_ten_d;
    logic [3:0] disp_unit_q, disp_unit_d;
    logic [3:0] disp_ten_q, disp_ten_d;
    logic       pm_q, pm_d;
    logic       tick_day_q, tick_day_d;

    logic       valid, at_23, at_00, inc, dec;
    logic [4:0] hour_bin, disp_bin;

    always_comb begin
        hour_unit_d = hour_unit_q;
        hour_ten_d  = hour_ten_q;
        tick_day_d  = 1'b0;

        valid = (hour_ten_q < 4'd2 && hour_unit_q <= 4'd9) ||
                (hour_ten_q == 4'd2 && hour_unit_q <= 4'd3);
        at_23 = (hour_ten_q == 4'd2) && (hour_unit_q == 4'd3);
        at_00 = (hour_ten_q == 4'd0) && (hour_unit_q == 4'd0);
        inc   = mode_hour ? tick_hour : (up & ~down);
        dec   = ~mode_hour & down & ~up;

        if (inc) begin
            if (!valid || at_23) begin
                hour_unit_d = '0;
                hour_ten_d  = '0;
                tick_day_d  = mode_hour & at_23;
            end else if (hour_unit_q == 4'd9) begin
                hour_unit_d = '0;
                hour_ten_d  = hour_ten_q + 4'd1;
            end else begin
                hour_unit_d = hour_unit_q + 4'd1;
            end
        end else if (dec) begin
            if (!valid) begin
                hour_unit_d = '0;
                hour_ten_d  = '0;
            end else if (at_00) begin
                hour_unit_d = 4'd3;
                hour_ten_d  = 4'd2;
            end else if (hour_unit_q == 4'd0) begin
                hour_unit_d = 4'd9;
                hour_ten_d  = hour_ten_q - 4'd1;
            end else begin
                hour_unit_d = hour_unit_q - 4'd1;
            end
        end

        // Display is derived from the next count so it lands on the same edge.
        hour_bin = 5'(hour_ten_d) * 5'd10 + 5'(hour_unit_d);
        pm_d     = (hour_bin >= 5'd12);
        disp_bin = hour_bin;
        if (fmt_12h) begin
            if (hour_bin == 5'd0) begin
                disp_bin = 5'd12;
            end else if (hour_bin > 5'd12) begin
                disp_bin = hour_bin - 5'd12;
            end
        end

        if (disp_bin >= 5'd20) begin
            disp_ten_d  = 4'd2;
            disp_unit_d = 4'(disp_bin - 5'd20);
        end else if (disp_bin >= 5'd10) begin
            disp_ten_d  = 4'd1;
            disp_unit_d = 4'(disp_bin - 5'd10);
        end else begin
            disp_ten_d  = 4'd0;
            disp_unit_d = 4'(disp_bin);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hour_unit_q <= '0;
            hour_ten_q  <= '0;
            disp_unit_q <= '0;
            disp_ten_q  <= '0;
            pm_q        <= 1'b0;
            tick_day_q  <= 1'b0;
        end else begin
            hour_unit_q <= hour_unit_d;
            hour_ten_q  <= hour_ten_d;
            disp_unit_q <= disp_unit_d;
            disp_ten_q  <= disp_ten_d;
            pm_q        <= pm_d;
            tick_day_q  <= tick_day_d;
        end
    end

    assign hour_unit = hour_unit_q;
    assign hour_ten  = hour_ten_q;
    assign disp_unit = disp_unit_q;
    assign disp_ten  = disp_ten_q;
    assign pm        = pm_q;
    assign tick_day  = tick_day_q;

endmodule

// File: tb/tb_counter_hours.sv
// Bench for counter_hours: directed sequences from the test plan plus random
// stimulus, checked against an integer-hour reference model.
module tb_counter_hours;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mode_hour = 1'b1;
    logic       up = 1'b0;
    logic       down = 1'b0;
    logic       tick_hour = 1'b0;
    logic       fmt_12h = 1'b0;
    logic [3:0] hour_unit, hour_ten, disp_unit, disp_ten;
    logic       pm, tick_day;

    int checks = 0;
    int failures = 0;

    // Reference model state: hour as plain integer 0..23.
    int model_hour = 0;
    int model_td = 0;

    counter_hours dut (
        .clk       (clk),
        .rst       (rst),
        .mode_hour (mode_hour),
        .up        (up),
        .down      (down),
        .tick_hour (tick_hour),
        .fmt_12h   (fmt_12h),
        .hour_unit (hour_unit),
        .hour_ten  (hour_ten),
        .disp_unit (disp_unit),
        .disp_ten  (disp_ten),
        .pm        (pm),
        .tick_day  (tick_day)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (hour=%0d t=%0t)", tag, got, exp, model_hour, $time);
        end
    endtask

    task automatic check_all();
        int disp;
        disp = model_hour;
        if (fmt_12h) disp = (model_hour % 12 == 0) ? 12 : model_hour % 12;
        check("hour_unit", int'(hour_unit), model_hour % 10);
        check("hour_ten",  int'(hour_ten),  model_hour / 10);
        check("disp_unit", int'(disp_unit), disp % 10);
        check("disp_ten",  int'(disp_ten),  disp / 10);
        check("pm",        int'(pm),        (model_hour >= 12) ? 1 : 0);
        check("tick_day",  int'(tick_day),  model_td);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_unit"},  int'(hour_unit), 0);
        check({tag, "_ten"},   int'(hour_ten),  0);
        check({tag, "_dunit"}, int'(disp_unit), 0);
        check({tag, "_dten"},  int'(disp_ten),  0);
        check({tag, "_pm"},    int'(pm),        0);
        check({tag, "_td"},    int'(tick_day),  0);
    endtask

    // Apply one cycle of inputs, advance the model, check after the edge.
    task automatic step(input logic m, input logic u, input logic d,
                        input logic t, input logic f);
        mode_hour = m; up = u; down = d; tick_hour = t; fmt_12h = f;
        @(posedge clk);
        #1;
        model_td = 0;
        if (m) begin
            if (t) begin
                if (model_hour == 23) model_td = 1;
                model_hour = (model_hour + 1) % 24;
            end
        end else if (u && !d) begin
            model_hour = (model_hour + 1) % 24;
        end else if (d && !u) begin
            model_hour = (model_hour + 23) % 24;
        end
        check_all();
    endtask

    task automatic set_to(input int target, input logic f);
        while (model_hour != target) step(1'b0, 1'b1, 1'b0, 1'b0, f);
    endtask

    initial begin
        rst = 1'b1;
        #13;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        model_hour = 0; model_td = 0;

        // 24 ticks in run mode, 24-hour format
        for (int i = 0; i < 24; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // wrap at 23 with up asserted in run mode
        for (int i = 0; i < 23; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        check("wrap_td", int'(tick_day), 1);

        // set mode decrement/increment boundaries
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("dec_00_23", int'(hour_ten) * 10 + int'(hour_unit), 23);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("dec_20_19", int'(hour_ten) * 10 + int'(hour_unit), 19);
        set_to(23, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("set_wrap_td", int'(tick_day), 0);
        set_to(7, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("both_hold", int'(hour_unit), 7);
        set_to(9, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // 12-hour display points
        set_to(0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        set_to(11, 1'b1);
        set_to(12, 1'b1);
        set_to(13, 1'b1);
        check("disp13", int'(disp_ten) * 10 + int'(disp_unit), 1);
        set_to(15, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // tick in set mode is dropped
        set_to(5, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // async reset right after a midnight carry
        set_to(23, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        model_hour = 0; model_td = 0;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);

        // randomized stimulus
        for (int i = 0; i < 3000; i++) begin
            step(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)),
                 logic'($urandom_range(0, 1)), logic'($urandom_range(0, 2) == 0),
                 logic'($urandom_range(0, 7) == 0 ? ~fmt_12h : fmt_12h));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
